// File: rtl/flght_pkg.sv
// Shared types and defaults for the flight sequencer.
package flght_pkg;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CAL,
        ST_RAMP,
        ST_RUN,
        ST_LAND,
        ST_FAULT
    } state_t;

    localparam int RAMP_STEP_DEF = 4;
    localparam int CAL_TMO_DEF   = 1_000_000;
    localparam int THR_W         = 9;
endpackage

// File: rtl/flght_seq_thrst_ramp.sv
// Thrust ramp limiter: one step up clamped to the target, or one step down floored at zero.
module thrst_ramp #(
    parameter int STEP = 4
) (
    input  logic [8:0] cur,
    input  logic [8:0] tgt,
    output logic [8:0] up,
    output logic [8:0] down
);
    localparam logic [9:0] STEP10 = 10'(STEP);

    logic [9:0] cur10;
    logic [9:0] tgt10;
    logic [9:0] sum;
    logic [9:0] diff;

    assign cur10 = {1'b0, cur};
    assign tgt10 = {1'b0, tgt};
    assign sum   = cur10 + STEP10;
    assign diff  = cur10 - STEP10;

    // sum >= cur, so cur above the target also lands on the target (clamp down).
    always_comb begin
        up   = (sum >= tgt10) ? tgt : sum[8:0];
        down = (cur10 <= STEP10) ? 9'd0 : diff[8:0];
    end
endmodule

// File: rtl/flght_seq.sv
// Flight sequencer: arm/calibrate/ramp/run/land state machine with registered outputs.
module flght_seq
    import flght_pkg::*;
#(
    parameter int RAMP_STEP = RAMP_STEP_DEF,
    parameter int CAL_TMO   = CAL_TMO_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       arm_req,
    input  logic       disarm_req,
    input  logic       kill,
    input  logic       cal_done,
    input  logic       vld,
    input  logic       batt_low,
    input  logic [8:0] thrst_in,
    output logic       strt_cal,
    output logic       inertial_cal,
    output logic       motors_off,
    output logic [8:0] thrst_out,
    output logic       armed,
    output logic       fault
);
    localparam int CW = (CAL_TMO > 1) ? $clog2(CAL_TMO) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CAL_TMO - 1);

    state_t      state;
    logic [CW-1:0] cnt;
    logic [8:0]  thr_up;
    logic [8:0]  thr_down;

    thrst_ramp #(.STEP(RAMP_STEP)) u_ramp (
        .cur  (thrst_out),
        .tgt  (thrst_in),
        .up   (thr_up),
        .down (thr_down)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            strt_cal     <= 1'b0;
            inertial_cal <= 1'b0;
            motors_off   <= 1'b1;
            thrst_out    <= '0;
            armed        <= 1'b0;
            fault        <= 1'b0;
        end else begin
            strt_cal <= 1'b0;
            if (kill && state != ST_FAULT) begin
                state        <= ST_IDLE;
                cnt          <= '0;
                inertial_cal <= 1'b0;
                motors_off   <= 1'b1;
                thrst_out    <= '0;
                armed        <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (arm_req) begin
                            state        <= ST_CAL;
                            strt_cal     <= 1'b1;
                            inertial_cal <= 1'b1;
                            motors_off   <= 1'b0;
                            cnt          <= '0;
                        end
                    end
                    // cal_done is tested first so it wins on the timeout cycle.
                    ST_CAL: begin
                        if (cal_done) begin
                            state        <= ST_RAMP;
                            inertial_cal <= 1'b0;
                            armed        <= 1'b1;
                        end else if (cnt == CNT_LAST) begin
                            state        <= ST_FAULT;
                            inertial_cal <= 1'b0;
                            motors_off   <= 1'b1;
                            fault        <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    ST_RAMP: begin
                        if (disarm_req || batt_low) begin
                            state <= ST_LAND;
                        end else if (vld) begin
                            thrst_out <= thr_up;
                            if (thr_up == thrst_in) state <= ST_RUN;
                        end
                    end
                    ST_RUN: begin
                        if (disarm_req || batt_low) state <= ST_LAND;
                        else                        thrst_out <= thrst_in;
                    end
                    ST_LAND: begin
                        if ((vld && thr_down == '0) || (!vld && thrst_out == '0)) begin
                            state      <= ST_IDLE;
                            motors_off <= 1'b1;
                            armed      <= 1'b0;
                        end
                        if (vld) thrst_out <= thr_down;
                    end
                    ST_FAULT: begin
                        state <= ST_FAULT;
                    end
                    default: begin
                        state      <= ST_IDLE;
                        motors_off <= 1'b1;
                        thrst_out  <= '0;
                        armed      <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: doc/flght_seq.md
FLGHT_SEQ -- requirements
Module: flght_seq

Interface
REQ-001 Parameter RAMP_STEP, default 4: thrust increment/decrement per vld pulse in RAMP and LAND.
REQ-002 Parameter CAL_TMO, default 1_000_000: clock cycles allowed for calibration before FAULT.
REQ-003 clk  in  1  single system clock; all state changes on its rising edge.
REQ-004 rst  in  1  reset; synchronous and active-high.
REQ-005 arm_req  in  1  one-cycle pulse requesting arm (calibrate, then fly).
REQ-006 disarm_req  in  1  one-cycle pulse requesting controlled descent.
REQ-007 kill  in  1  level; immediate motor stop from any state.
REQ-008 cal_done  in  1  one-cycle pulse from inertial interface; calibration complete.
REQ-009 vld  in  1  new inertial reading strobe; paces the thrust ramps.
REQ-010 batt_low  in  1  level; forces descent while flying.
REQ-011 thrst_in  in  9  unsigned thrust from slider/command.
REQ-012 strt_cal  out  1  one-cycle pulse starting inertial calibration.
REQ-013 inertial_cal  out  1  high throughout CAL; motor mixer runs motors at calibration speed.
REQ-014 motors_off  out  1  high when motor outputs must be forced to zero.
REQ-015 thrst_out  out  9  unsigned sequenced thrust to the motor mixer.
REQ-016 armed  out  1  high in RAMP, RUN and LAND.
REQ-017 fault  out  1  sticky calibration-timeout flag.

Function
REQ-018 States SHALL be IDLE, CAL, RAMP, RUN, LAND and FAULT.
REQ-019 IDLE: motors_off=1, thrst_out=0; arm_req -> CAL with strt_cal pulsed in the transition cycle.
REQ-020 CAL: inertial_cal=1, motors_off=0, thrst_out=0; cycle counter increments from 0.
REQ-021 CAL: cal_done -> RAMP; counter reaching CAL_TMO-1 without cal_done -> FAULT; cal_done on the timeout cycle SHALL win.
REQ-022 RAMP: on each vld, thrst_out += RAMP_STEP, clamped to thrst_in; when thrst_out equals thrst_in after update -> RUN.
REQ-023 RUN: thrst_out tracks thrst_in directly with one cycle of register latency.
REQ-024 RAMP or RUN with disarm_req or batt_low -> LAND.
REQ-025 LAND: on each vld, thrst_out -= RAMP_STEP, floored at 0; when thrst_out equals 0 -> IDLE; arm_req ignored.
REQ-026 FAULT: motors_off=1, fault=1, thrst_out=0; exit only via rst.
REQ-027 kill SHALL force IDLE next cycle from every state except FAULT, overriding all simultaneous requests; thrst_out=0.
REQ-028 Ramp arithmetic SHALL use 10-bit intermediates; no wrap at 511 or below 0.
REQ-029 thrst_in below the current thrst_out during RAMP -> thrst_out clamps down to thrst_in, then RUN.
REQ-030 arm_req outside IDLE and disarm_req outside RAMP/RUN SHALL be ignored.
REQ-031 All outputs SHALL be registered; strt_cal SHALL be high for exactly one cycle per arm.

Reset
REQ-032 rst SHALL put the block in IDLE: motors_off=1, thrst_out=0, strt_cal=0, inertial_cal=0, armed=0, fault=0, counter=0.
REQ-033 rst asserted mid-CAL, mid-RAMP or in FAULT SHALL take effect on the next edge, with no residual pulse.

Structure
REQ-034 The state enum and RAMP_STEP/CAL_TMO defaults SHALL live in shared package flght_pkg.
REQ-035 The ramp limiter (step, clamp, floor) SHALL be one sub-module, thrst_ramp; everything else is flat.

Verification
REQ-036 arm_req, cal_done after 100 cycles, thrst_in=20, vld every 10 cycles -> thrst_out 4,8,12,16,20, then RUN.
REQ-037 CAL_TMO=50, arm_req with no cal_done -> FAULT at cycle 50, fault=1, motors_off=1; stays until rst.
REQ-038 RUN at thrst_in=10, batt_low=1 -> LAND; thrst_out 6,2,0 on successive vld -> IDLE.
REQ-039 kill during RAMP at thrst_out=12 -> next cycle IDLE, thrst_out=0, motors_off=1.
REQ-040 thrst_in=509, RAMP_STEP=4 -> thrst_out clamps at 509, no wrap; arm_req and cal_done in the same cycle in CAL -> RAMP.
REQ-041 rst pulse mid-RAMP -> all outputs at reset values on the next cycle.
